// File: rtl/mmio_seg_display_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
//   Shared definitions for the mmio_seg_display front-panel peripheral:
//   register indices, CTRL register layout and the hex-to-seven-segment
//   lookup used by the display driver.
// -----------------------------------------------------------------------------
package io_pkg;

  // Register indices on i_addr. Display value registers start at REG_DISP0
  // and occupy NUM_DISP consecutive indices.
  localparam logic [2:0] REG_LED   = 3'd0;
  localparam logic [2:0] REG_SW    = 3'd1;
  localparam logic [2:0] REG_DISP0 = 3'd2;
  localparam logic [2:0] REG_DP    = 3'd6;
  localparam logic [2:0] REG_CTRL  = 3'd7;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLANK_BIT = 1;

  typedef struct packed {
    logic blank;  // bit 1: blank leading zero digits
    logic en;     // bit 0: drive the displays
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{blank: 1'b0, en: 1'b1};

  // Hex nibble -> active-low segments {g,f,e,d,c,b,a}; b and d are lowercase.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b100_0000;
      4'h1: seg = 7'b111_1001;
      4'h2: seg = 7'b010_0100;
      4'h3: seg = 7'b011_0000;
      4'h4: seg = 7'b001_1001;
      4'h5: seg = 7'b001_0010;
      4'h6: seg = 7'b000_0010;
      4'h7: seg = 7'b111_1000;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b001_0000;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b000_0011;
      4'hC: seg = 7'b100_0110;
      4'hD: seg = 7'b010_0001;
      4'hE: seg = 7'b000_0110;
      default: seg = 7'b000_1110;  // F
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mmio_seg_display_sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Two-flop synchroniser followed by a per-bit stability counter. A
//   debounced bit only follows its synchronised input after the two have
//   disagreed for DEBOUNCE_CYC consecutive cycles; any agreement in between
//   restarts that bit's count.
// Ports
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   sw_i    raw asynchronous switch inputs
//   sw_o    debounced switch state
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int SW_W         = 16,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] sw_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SW_W-1:0]  sync1_q, sync2_q;
  logic [SW_W-1:0]  deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [SW_W];
  logic [CNT_W-1:0] cnt_d [SW_W];

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path can leave it holding state (latch).
    deb_d = deb_q;
    for (int b = 0; b < SW_W; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          deb_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset element by element; a true memory would be left unreset.
      for (int b = 0; b < SW_W; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int b = 0; b < SW_W; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  assign sw_o = deb_q;

endmodule

// File: rtl/mmio_seg_display.sv
// -----------------------------------------------------------------------------
// mmio_seg_display
//   Memory-mapped front-panel peripheral: LED register, debounced switch
//   register and a time-multiplexed driver for NUM_DISP seven-segment
//   displays of DIGITS digits each.
// Ports
//   i_mclk / i_reset      clock, asynchronous active-low reset
//   i_we, i_re, i_addr    register write/read strobes and register index
//   i_wdata               write data
//   o_rdata, o_rvalid     read data and its one-cycle valid, one cycle after i_re
//   i_sw                  raw switches
//   o_led                 LED drive, active-high
//   o_seg                 per display {dp,g..a}, active-low
//   o_an                  per display digit enables, active-low
// Register map: 0 LED, 1 SW (ro), 2.. DISPn, 6 DP, 7 CTRL {blank,en}.
// -----------------------------------------------------------------------------
module mmio_seg_display
  import io_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int NUM_DISP     = 2,
  parameter int DIGITS       = 4,
  parameter int SW_W         = 16,
  parameter int LED_W        = 16,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                       i_mclk,
  input  logic                       i_reset,
  input  logic                       i_we,
  input  logic                       i_re,
  input  logic [2:0]                 i_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_rvalid,
  input  logic [SW_W-1:0]            i_sw,
  output logic [LED_W-1:0]           o_led,
  output logic [NUM_DISP*8-1:0]      o_seg,
  output logic [NUM_DISP*DIGITS-1:0] o_an
);

  localparam int DISP_W = DIGITS * 4;
  localparam int DP_W   = NUM_DISP * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W  = $clog2(REFRESH_DIV);

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Register file
  logic [LED_W-1:0]                  led_q, led_d;
  logic [NUM_DISP-1:0][DISP_W-1:0]   disp_q, disp_d;
  logic [DP_W-1:0]                   dp_q, dp_d;
  ctrl_t                             ctrl_q, ctrl_d;

  // Read port
  logic [DATA_W-1:0]                 rdata_q, rdata_d;
  logic                              rvalid_q;

  // Refresh scan
  logic [REF_W-1:0]                  refresh_q, refresh_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;

  // Display outputs and per-display intermediates
  logic [NUM_DISP*8-1:0]             seg_q, seg_d;
  logic [DP_W-1:0]                   an_q, an_d;
  logic [NUM_DISP-1:0][3:0]          cur_nib;
  logic [NUM_DISP-1:0]               cur_dp;
  logic [NUM_DISP-1:0]               upper_nz;
  logic [NUM_DISP-1:0]               blank;

  logic [SW_W-1:0]                   sw_deb;
  logic                              unused_wdata;

  // Only the low bits of each register are meaningful; the rest of the bus
  // is intentionally ignored.
  assign unused_wdata = ^i_wdata;

  sw_debounce #(
    .SW_W         (SW_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk_i  (i_mclk),
    .rst_ni (i_reset),
    .sw_i   (i_sw),
    .sw_o   (sw_deb)
  );

  // Register writes. Unmapped indices (including DISP slots beyond NUM_DISP)
  // fall through and leave every register unchanged.
  always_comb begin
    led_d  = led_q;
    disp_d = disp_q;
    dp_d   = dp_q;
    ctrl_d = ctrl_q;
    if (i_we) begin
      if (i_addr == REG_LED) led_d = i_wdata[LED_W-1:0];
      if (i_addr == REG_DP)  dp_d  = i_wdata[DP_W-1:0];
      if (i_addr == REG_CTRL) begin
        ctrl_d.en    = i_wdata[CTRL_EN_BIT];
        ctrl_d.blank = i_wdata[CTRL_BLANK_BIT];
      end
      for (int d = 0; d < NUM_DISP; d++) begin
        if (i_addr == REG_DISP0 + 3'(d)) disp_d[d] = i_wdata[DISP_W-1:0];
      end
    end
  end

  // Read mux sees the pre-write register values, so a same-cycle read and
  // write of one index returns the old contents.
  always_comb begin
    rdata_d = '0;
    case (i_addr)
      REG_LED:  rdata_d[LED_W-1:0] = led_q;
      REG_SW:   rdata_d[SW_W-1:0]  = sw_deb;
      REG_DP:   rdata_d[DP_W-1:0]  = dp_q;
      REG_CTRL: rdata_d[1:0]       = ctrl_q;
      default: begin
        for (int d = 0; d < NUM_DISP; d++) begin
          if (i_addr == REG_DISP0 + 3'(d)) rdata_d[DISP_W-1:0] = disp_q[d];
        end
      end
    endcase
  end

  // Refresh counter runs regardless of CTRL.en so re-enabling resumes the
  // scan without a restart.
  always_comb begin
    refresh_d = refresh_q + REF_W'(1);
    idx_d     = idx_q;
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Segment/anode generation for the currently selected digit. A digit above
  // position 0 is blanked when it and every higher digit are zero; dp is
  // still driven on a blanked digit.
  always_comb begin
    seg_d    = '1;
    an_d     = '1;
    cur_nib  = '0;
    cur_dp   = '0;
    upper_nz = '0;
    blank    = '0;
    for (int d = 0; d < NUM_DISP; d++) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          cur_nib[d] = disp_q[d][k*4 +: 4];
          cur_dp[d]  = dp_q[d*DIGITS + k];
        end
        if ((IDX_W'(k) >= idx_q) && (disp_q[d][k*4 +: 4] != 4'h0)) upper_nz[d] = 1'b1;
      end
      blank[d] = ctrl_q.blank && (idx_q != '0) && !upper_nz[d];
      if (ctrl_q.en) begin
        seg_d[d*8 +: 8] = {~cur_dp[d], blank[d] ? 7'h7F : hex_to_seg(cur_nib[d])};
        for (int k = 0; k < DIGITS; k++) begin
          an_d[d*DIGITS + k] = (idx_q != IDX_W'(k));
        end
      end
    end
  end

  always_ff @(posedge i_mclk or negedge i_reset) begin
    if (!i_reset) begin
      led_q     <= '0;
      disp_q    <= '0;
      dp_q      <= '0;
      ctrl_q    <= CTRL_RESET;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      refresh_q <= '0;
      idx_q     <= '0;
      seg_q     <= '1;
      an_q      <= '1;
    end else begin
      led_q     <= led_d;
      disp_q    <= disp_d;
      dp_q      <= dp_d;
      ctrl_q    <= ctrl_d;
      rvalid_q  <= i_re;
      if (i_re) rdata_q <= rdata_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign o_led    = led_q;
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_seg    = seg_q;
  assign o_an     = an_q;

endmodule

// File: tb/tb_mmio_seg_display.sv
// -----------------------------------------------------------------------------
// tb_mmio_seg_display
//   Directed and randomised stimulus for mmio_seg_display with
//   NUM_DISP=2, DIGITS=4, REFRESH_DIV=4, DEBOUNCE_CYC=16. Expected values
//   come from a behavioural model: register shadows, a refresh position
//   derived from the cycle count since reset, and a sliding-window switch
//   debouncer.
// -----------------------------------------------------------------------------
module tb_mmio_seg_display;

  localparam int DATA_W       = 64;
  localparam int NUM_DISP     = 2;
  localparam int DIGITS       = 4;
  localparam int SW_W         = 16;
  localparam int LED_W        = 16;
  localparam int REFRESH_DIV  = 4;
  localparam int DEBOUNCE_CYC = 16;

  // Active-low {g..a} patterns for hex 0-F.
  localparam logic [6:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic                       i_mclk = 1'b0;
  logic                       i_reset = 1'b0;
  logic                       i_we = 1'b0;
  logic                       i_re = 1'b0;
  logic [2:0]                 i_addr = '0;
  logic [DATA_W-1:0]          i_wdata = '0;
  logic [SW_W-1:0]            i_sw = '0;
  logic [DATA_W-1:0]          o_rdata;
  logic                       o_rvalid;
  logic [LED_W-1:0]           o_led;
  logic [NUM_DISP*8-1:0]      o_seg;
  logic [NUM_DISP*DIGITS-1:0] o_an;

  mmio_seg_display #(
    .DATA_W       (DATA_W),
    .NUM_DISP     (NUM_DISP),
    .DIGITS       (DIGITS),
    .SW_W         (SW_W),
    .LED_W        (LED_W),
    .REFRESH_DIV  (REFRESH_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) dut (
    .i_mclk   (i_mclk),
    .i_reset  (i_reset),
    .i_we     (i_we),
    .i_re     (i_re),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_rdata  (o_rdata),
    .o_rvalid (o_rvalid),
    .i_sw     (i_sw),
    .o_led    (o_led),
    .o_seg    (o_seg),
    .o_an     (o_an)
  );

  always #5 i_mclk = ~i_mclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [LED_W-1:0]  m_led;
  logic [15:0]       m_disp [NUM_DISP];
  logic [7:0]        m_dp;
  logic [1:0]        m_ctrl;

  int                ecnt;                      // clock edges since reset release
  logic [SW_W-1:0]   hist [0:DEBOUNCE_CYC];     // hist[k] = raw switches k+1 edges ago
  logic [SW_W-1:0]   sw_model;

  // A bit flips once the synchronised samples (raw delayed two edges) have
  // shown the opposite value for the last DEBOUNCE_CYC edges.
  function automatic logic [SW_W-1:0] deb_next();
    logic [SW_W-1:0] r = sw_model;
    for (int b = 0; b < SW_W; b++) begin
      bit all_flip = 1'b1;
      for (int k = 1; k <= DEBOUNCE_CYC; k++) begin
        if (hist[k][b] == sw_model[b]) all_flip = 1'b0;
      end
      if (all_flip) r[b] = ~sw_model[b];
    end
    return r;
  endfunction

  always @(posedge i_mclk or negedge i_reset) begin
    if (!i_reset) begin
      ecnt     <= 0;
      sw_model <= '0;
      for (int k = 0; k <= DEBOUNCE_CYC; k++) hist[k] <= '0;
    end else begin
      ecnt     <= ecnt + 1;
      sw_model <= deb_next();
      hist[0]  <= i_sw;
      for (int k = 1; k <= DEBOUNCE_CYC; k++) hist[k] <= hist[k-1];
    end
  end

  function automatic logic [63:0] exp_reg(input logic [2:0] a);
    case (a)
      3'd0:    return 64'(m_led);
      3'd1:    return 64'(sw_model);
      3'd2:    return 64'(m_disp[0]);
      3'd3:    return 64'(m_disp[1]);
      3'd6:    return 64'(m_dp);
      3'd7:    return 64'(m_ctrl);
      default: return 64'd0;
    endcase
  endfunction

  // Expected outputs after edge n: digit shown is ((n-1)/REFRESH_DIV) mod DIGITS.
  function automatic void exp_out(input int n, output logic [7:0] an, output logic [15:0] seg);
    an  = 8'hFF;
    seg = 16'hFFFF;
    if (n >= 1 && m_ctrl[0]) begin
      int d = ((n - 1) / REFRESH_DIV) % DIGITS;
      for (int p = 0; p < NUM_DISP; p++) begin
        logic [15:0] v   = m_disp[p] >> (4 * d);
        logic [3:0]  nib = v[3:0];
        bit          blk = m_ctrl[1] && (d > 0) && (v == 16'd0);
        an[p*DIGITS + d] = 1'b0;
        seg[p*8 +: 8]    = {~m_dp[p*DIGITS + d], blk ? 7'h7F : HEX7[nib]};
      end
    end
  endfunction

  // ---------------- bus helpers (entered and left at a negedge) ----------------
  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    i_we = 1'b1; i_addr = a; i_wdata = d;
    @(posedge i_mclk);
    @(negedge i_mclk);
    i_we = 1'b0;
    case (a)
      3'd0: m_led     = d[15:0];
      3'd2: m_disp[0] = d[15:0];
      3'd3: m_disp[1] = d[15:0];
      3'd6: m_dp      = d[7:0];
      3'd7: m_ctrl    = d[1:0];
      default: ;
    endcase
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [63:0] exp);
    i_re = 1'b1; i_addr = a;
    @(posedge i_mclk);
    @(negedge i_mclk);
    i_re = 1'b0;
    check({tag, "_rvalid"}, 64'(o_rvalid), 64'd1);
    check({tag, "_rdata"}, o_rdata, exp);
  endtask

  task automatic scan(input string tag, input int cycles);
    logic [7:0]  ea;
    logic [15:0] es;
    @(negedge i_mclk);
    repeat (cycles) begin
      @(negedge i_mclk);
      exp_out(ecnt, ea, es);
      check({tag, "_an"}, 64'(o_an), 64'(ea));
      check({tag, "_seg"}, 64'(o_seg), 64'(es));
    end
  endtask

  // Find digit 0 of display p, then step one refresh period per digit.
  task automatic digit_seq(input string tag, input int p, input logic [7:0] e [4]);
    bit found = 1'b0;
    for (int c = 0; c < 2 * REFRESH_DIV * DIGITS && !found; c++) begin
      @(negedge i_mclk);
      if (o_an[p*DIGITS +: DIGITS] == 4'b1110) found = 1'b1;
    end
    check({tag, "_sync"}, 64'(found), 64'd1);
    for (int k = 0; k < DIGITS; k++) begin
      check($sformatf("%s_d%0d", tag, k), 64'(o_seg[p*8 +: 8]), 64'(e[k]));
      repeat (REFRESH_DIV) @(negedge i_mclk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          first_one;
    int          b;
    logic [7:0]  exp_d0 [4];
    logic [7:0]  exp_d1 [4];

    m_led = '0; m_disp[0] = '0; m_disp[1] = '0; m_dp = '0; m_ctrl = 2'b01;

    // 1: reset state and refresh rotation
    repeat (3) @(negedge i_mclk);
    check("rst_an", 64'(o_an), 64'hFF);
    check("rst_seg", 64'(o_seg), 64'hFFFF);
    check("rst_led", 64'(o_led), 64'd0);
    check("rst_rvalid", 64'(o_rvalid), 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    i_reset = 1'b1;
    scan("refresh", 16);
    rd_check("ctrl_rst", 3'd7, exp_reg(3'd7));
    rd_check("sw_rst", 3'd1, exp_reg(3'd1));

    // 2: hex digits on display 0
    wr(3'd2, 64'hFFFF_FFFF_FFFF_12AF);
    wr(3'd7, 64'd1);
    rd_check("disp0_rd", 3'd2, exp_reg(3'd2));
    scan("hex", 16);
    exp_d0 = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    digit_seq("disp0", 0, exp_d0);

    // 3: leading-zero blanking on display 1
    wr(3'd3, 64'h0030);
    wr(3'd7, 64'h3);
    scan("blank", 16);
    exp_d1 = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
    digit_seq("disp1", 1, exp_d1);

    // Upper bits of writes are dropped on readback
    wr(3'd7, '1);
    rd_check("ctrl_mask", 3'd7, exp_reg(3'd7));
    wr(3'd6, 64'hFFFF_FFFF_FFFF_FF5A);
    rd_check("dp_mask", 3'd6, exp_reg(3'd6));

    // Randomised display contents, dp bits and CTRL
    for (int i = 0; i < 6; i++) begin
      wr(3'd2, 64'(16'($urandom) >> (4 * $urandom_range(0, 3))));
      wr(3'd3, 64'(16'($urandom) >> (4 * $urandom_range(0, 3))));
      wr(3'd6, 64'($urandom));
      wr(3'd7, 64'($urandom_range(0, 3)));
      scan($sformatf("rand%0d", i), 16);
    end

    // 4: bouncing switch, then stable high
    for (int t = 0; t < 4; t++) begin
      i_sw[0] = ~i_sw[0];
      repeat (5) rd_check("sw_bounce", 3'd1, exp_reg(3'd1));
    end
    i_sw[0] = 1'b1;
    first_one = -1;
    for (int c = 0; c < 24; c++) begin
      rd_check("sw_settle", 3'd1, exp_reg(3'd1));
      if (o_rdata[0] && first_one < 0) first_one = c;
    end
    check("sw_latency", 64'(first_one), 64'(DEBOUNCE_CYC + 2));

    // Random switch activity: occasional new words plus single-bit glitches
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 19) == 0) i_sw = 16'($urandom);
      else if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, SW_W - 1);
        i_sw[b] = ~i_sw[b];
      end
      rd_check("sw_rand", 3'd1, exp_reg(3'd1));
    end

    // 5: same-cycle write and read of LED returns the old value
    wr(3'd0, 64'h1234);
    i_we = 1'b1; i_re = 1'b1; i_addr = 3'd0; i_wdata = 64'hBEEF;
    @(posedge i_mclk);
    @(negedge i_mclk);
    i_we = 1'b0; i_re = 1'b0;
    m_led = 16'hBEEF;
    check("rw_same_rdata", o_rdata, 64'h1234);
    check("rw_same_rvalid", 64'(o_rvalid), 64'd1);
    check("rw_same_led", 64'(o_led), 64'hBEEF);
    @(negedge i_mclk);
    check("rvalid_one_cycle", 64'(o_rvalid), 64'd0);
    rd_check("led_after", 3'd0, exp_reg(3'd0));

    // 6: unmapped index, then reset with a read pending
    wr(3'd5, 64'($urandom));
    rd_check("unmapped", 3'd5, 64'd0);
    rd_check("unmapped4", 3'd4, 64'd0);
    i_re = 1'b1; i_addr = 3'd0;
    @(posedge i_mclk);
    #1;
    check("rvalid_pending", 64'(o_rvalid), 64'd1);
    i_reset = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(o_rvalid), 64'd0);
    check("rst_mid_rdata", o_rdata, 64'd0);
    check("rst_mid_an", 64'(o_an), 64'hFF);
    check("rst_mid_seg", 64'(o_seg), 64'hFFFF);
    check("rst_mid_led", 64'(o_led), 64'd0);
    i_re = 1'b0;
    @(negedge i_mclk);
    i_sw = '0;
    i_reset = 1'b1;
    m_led = '0; m_disp[0] = '0; m_disp[1] = '0; m_dp = '0; m_ctrl = 2'b01;
    rd_check("ctrl_rst2", 3'd7, exp_reg(3'd7));
    rd_check("disp0_rst2", 3'd2, exp_reg(3'd2));
    scan("refresh2", 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
